branch_predictor_bht: RTL and testbench

//   Dynamic branch predictor replacing static predict-not-taken. IF stage looks up a direct-mapped
//   BHT/BTB: 2-bit saturating counter, tag and target per entry. EX stage resolves the branch and

---
 rtl/branch_pred_pkg.sv | 8 +
 rtl/bht_table.sv | 48 ++++
 rtl/branch_predictor_bht.sv | 66 ++++++
 tb/tb_branch_predictor_bht.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// branch_pred_pkg: 2-bit saturating counter encodings and step function shared by the predictor.
package branch_pred_pkg;
    localparam int CTR_W = 2;
    typedef enum logic [CTR_W-1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
    function automatic ctr_e sat_step(ctr_e cnt, logic taken);
        return taken ? (cnt == ST ? ST : ctr_e'(cnt + 2'd1)) : (cnt == SNT ? SNT : ctr_e'(cnt - 2'd1));
    endfunction
endpackage

// File: rtl/bht_table.sv
// bht_table: direct-mapped BHT/BTB with async clear, a combinational lookup port and a training write port.
module bht_table import branch_pred_pkg::*; #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    input  logic [TAG_BITS-1:0]   rd_tag_i,
    output logic                  rd_hit_o,
    output logic                  rd_taken_o,
    output logic [ADDR_WIDTH-1:0] rd_target_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic                  wr_taken_i,
    input  logic [ADDR_WIDTH-1:0] wr_target_i
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    logic                  valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    ctr_e                  ctr_q    [ENTRIES];
    logic                  wr_hit;
    ctr_e                  ctr_d;
    assign rd_hit_o    = valid_q[rd_idx_i] && tag_q[rd_idx_i] == rd_tag_i;
    assign rd_taken_o  = ctr_q[rd_idx_i][1];
    assign rd_target_o = target_q[rd_idx_i];
    assign wr_hit      = valid_q[wr_idx_i] && tag_q[wr_idx_i] == wr_tag_i;
    // A miss only allocates when taken, and always starts weakly taken.
    assign ctr_d       = wr_hit ? sat_step(ctr_q[wr_idx_i], wr_taken_i) : WT;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (wr_en_i && (wr_hit || wr_taken_i)) begin
            valid_q[wr_idx_i] <= 1'b1;
            tag_q[wr_idx_i]   <= wr_tag_i;
            ctr_q[wr_idx_i]   <= ctr_d;
            if (wr_taken_i) target_q[wr_idx_i] <= wr_target_i;
        end
    end
endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: IF-stage dynamic prediction, EX-stage training, mispredict redirect/flush and stats.
module branch_predictor_bht import branch_pred_pkg::*; #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  ex_valid,
    input  logic                  ex_is_branch,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic                  ex_taken,
    input  logic [ADDR_WIDTH-1:0] ex_target,
    input  logic                  ex_pred_taken,
    input  logic [ADDR_WIDTH-1:0] ex_pred_target,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  IF_flush,
    output logic                  ID_flush,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispred_count
);
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
    logic                  rd_hit, rd_taken, resolve;
    logic [ADDR_WIDTH-1:0] rd_target;
    logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d, mispred_count_q, mispred_count_d;
    bht_table #(.ADDR_WIDTH(ADDR_WIDTH), .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_table (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (if_pc[INDEX_BITS+1:2]),
        .rd_tag_i    (if_pc[ADDR_WIDTH-1:INDEX_BITS+2]),
        .rd_hit_o    (rd_hit),
        .rd_taken_o  (rd_taken),
        .rd_target_o (rd_target),
        .wr_en_i     (resolve),
        .wr_idx_i    (ex_pc[INDEX_BITS+1:2]),
        .wr_tag_i    (ex_pc[ADDR_WIDTH-1:INDEX_BITS+2]),
        .wr_taken_i  (ex_taken),
        .wr_target_i (ex_target)
    );
    assign pred_taken  = rd_hit && rd_taken;
    assign pred_target = pred_taken ? rd_target : if_pc + ADDR_WIDTH'(4);
    // Gating with rst keeps redirects quiet while reset holds, whatever EX still shows.
    assign resolve     = ex_valid && ex_is_branch && !rst;
    assign mispredict  = resolve && ((ex_taken != ex_pred_taken) ||
                         (ex_taken && ex_pred_taken && ex_target != ex_pred_target));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + ADDR_WIDTH'(4);
    assign IF_flush    = mispredict;
    assign ID_flush    = mispredict;
    assign branch_count_d  = branch_count_q + CNT_WIDTH'(resolve && !(&branch_count_q));
    assign mispred_count_d = mispred_count_q + CNT_WIDTH'(mispredict && !(&mispred_count_q));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end
    assign branch_count  = branch_count_q;
    assign mispred_count = mispred_count_q;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: vector table through a scoreboard queue, plus saturation and mid-stream reset sequences.
module tb_branch_predictor_bht;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    typedef struct {
        logic [31:0] if_pc;
        logic        ex_valid, ex_br;
        logic [31:0] ex_pc;
        logic        ex_tk;
        logic [31:0] ex_tgt;
        logic        ex_ptk;
        logic [31:0] ex_ptgt;
        logic        e_ptk;
        logic [31:0] e_ptgt;
        logic        e_misp;
        logic [31:0] e_redir;
    } vec_t;
    logic          clk = 0, rst = 1;
    logic [31:0]   if_pc = 0, ex_pc = 0, ex_target = 0, ex_pred_target = 0;
    logic          ex_valid = 0, ex_is_branch = 0, ex_taken = 0, ex_pred_taken = 0;
    logic          pred_taken, mispredict, IF_flush, ID_flush;
    logic [31:0]   pred_target, redirect_pc;
    logic [CW-1:0] branch_count, mispred_count;
    int            checks = 0, errors = 0, bc = 0, mc = 0;
    vec_t          vecs[$], sb[$], e;
    branch_predictor_bht #(.ADDR_WIDTH(32), .INDEX_BITS(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .IF_flush(IF_flush), .ID_flush(ID_flush),
        .branch_count(branch_count), .mispred_count(mispred_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endtask
    function automatic vec_t mk(logic [31:0] ifp, logic v, logic b, logic [31:0] pc, logic tk, logic [31:0] tgt,
                                logic ptk, logic [31:0] ptgt, logic eptk, logic [31:0] eptgt, logic emisp,
                                logic [31:0] eredir);
        return '{ifp, v, b, pc, tk, tgt, ptk, ptgt, eptk, eptgt, emisp, eredir};
    endfunction
    task automatic drive(input vec_t v);
        if_pc = v.if_pc; ex_valid = v.ex_valid; ex_is_branch = v.ex_br; ex_pc = v.ex_pc;
        ex_taken = v.ex_tk; ex_target = v.ex_tgt; ex_pred_taken = v.ex_ptk; ex_pred_target = v.ex_ptgt;
    endtask
    task automatic check_stats(input string n);
        chk({n, " branch_count"}, 32'(branch_count), bc);
        chk({n, " mispred_count"}, 32'(mispred_count), mc);
    endtask
    task automatic model_step(input vec_t v);
        if (v.ex_valid && v.ex_br) bc = (bc == CMAX) ? CMAX : bc + 1;
        if (v.e_misp) mc = (mc == CMAX) ? CMAX : mc + 1;
    endtask
    initial begin
        vecs.push_back(mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80));
        vecs.push_back(mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104));
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h80, 0, 32'h104, 0, 32'h104, 0, 0));
        vecs.push_back(mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
        vecs.push_back(mk(32'h140, 1, 1, 32'h140, 1, 32'h200, 0, 32'h144, 0, 32'h144, 1, 32'h200));
        vecs.push_back(mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
        vecs.push_back(mk(32'h140, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0));
        vecs.push_back(mk(32'h140, 1, 1, 32'h140, 1, 32'h90, 1, 32'h80, 1, 32'h200, 1, 32'h90));
        vecs.push_back(mk(32'h140, 1, 0, 32'h140, 1, 32'h90, 0, 0, 1, 32'h90, 0, 0));
        vecs.push_back(mk(32'h140, 0, 1, 32'h140, 1, 32'h90, 0, 0, 1, 32'h90, 0, 0));
        vecs.push_back(mk(32'h140, 1, 1, 32'h140, 1, 32'h90, 1, 32'h90, 1, 32'h90, 0, 0));
        vecs.push_back(mk(32'hFFFFFFFC, 1, 1, 32'hFFFFFFFC, 0, 32'h10, 1, 32'h10, 0, 32'h0, 1, 32'h0));
        vecs.push_back(mk(32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(32'h141, 1, 1, 32'h142, 0, 32'h90, 1, 32'h90, 1, 32'h90, 1, 32'h146));
        vecs.push_back(mk(32'h140, 0, 0, 0, 0, 0, 0, 0, 1, 32'h90, 0, 0));
        // Reset state, with a would-be mispredict presented on EX
        if_pc = 32'h100; ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_target = 32'h80;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset pred_taken", 32'(pred_taken), 0);
        chk("reset pred_target", pred_target, 32'h104);
        chk("reset mispredict", 32'(mispredict), 0);
        check_stats("reset");
        ex_valid = 0;
        rst = 0;
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(e.e_ptk));
            chk($sformatf("v%0d pred_target", i), pred_target, e.e_ptgt);
            chk($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(e.e_misp));
            chk($sformatf("v%0d flushes", i), {30'd0, IF_flush, ID_flush}, {30'd0, e.e_misp, e.e_misp});
            if (e.e_misp) chk($sformatf("v%0d redirect_pc", i), redirect_pc, e.e_redir);
            check_stats($sformatf("v%0d", i));
            model_step(e);
        end
        // Drive stats past all-ones; both must stick at the maximum
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            e = mk(32'h204, 1, 1, 32'h204, 1, 32'h300, 0, 32'h208, 0, 0, 1, 32'h300);
            drive(e);
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("sat%0d mispredict", i), 32'(mispredict), 1);
            check_stats($sformatf("sat%0d", i));
            model_step(e);
        end
        @(posedge clk); #1;
        ex_valid = 0;
        if_pc = 32'h204;
        @(negedge clk);
        chk("sat branch_count max", 32'(branch_count), CMAX);
        chk("sat mispred_count max", 32'(mispred_count), CMAX);
        chk("0x204 pred_taken", 32'(pred_taken), 1);
        chk("0x204 pred_target", pred_target, 32'h300);
        // Asynchronous reset mid-cycle clears table and stats at once
        if_pc = 32'h140;
        ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h140; ex_taken = 0; ex_pred_taken = 1;
        #1;
        chk("pre-rst pred_taken", 32'(pred_taken), 1);
        chk("pre-rst mispredict", 32'(mispredict), 1);
        #1 rst = 1;
        #1;
        chk("rst pred_taken", 32'(pred_taken), 0);
        chk("rst pred_target", pred_target, 32'h144);
        chk("rst mispredict", 32'(mispredict), 0);
        chk("rst IF_flush", 32'(IF_flush), 0);
        chk("rst branch_count", 32'(branch_count), 0);
        chk("rst mispred_count", 32'(mispred_count), 0);
        if_pc = 32'h204;
        #1;
        chk("rst 0x204 pred_taken", 32'(pred_taken), 0);
        chk("rst 0x204 pred_target", pred_target, 32'h208);
        @(posedge clk); #1;
        rst = 0;
        ex_valid = 0;
        if_pc = 32'h140;
        @(negedge clk);
        chk("post-rst pred_taken", 32'(pred_taken), 0);
        chk("post-rst branch_count", 32'(branch_count), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
